// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the instruction-bus, redirect and decode-side
// signals of the fetch front end.
//
//   master modport : used by fetch_queue (drives imem_addr/imem_req and id_*)
//   slave  modport : used by the environment (memory, execute and decode)
//
// Handshake semantics (the only place they are written down):
//   imem  : a fetch transfers in any cycle where imem_req && imem_ready.
//           imem_data belongs to imem_addr in that same cycle. While
//           imem_req is high and imem_ready is low, imem_addr stays stable
//           and the request repeats in the next cycle.
//   decode: the head entry transfers in any cycle where
//           id_valid && !id_stall && !redirect_valid. While id_stall is
//           high, id_valid/id_pc/id_instr stay stable.
//   redirect_valid has priority over both transfers in its cycle.
interface fetch_queue_if;
  logic [11:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic        imem_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_instr;

  modport master (
    output imem_addr, imem_req, id_valid, id_pc, id_instr,
    input  imem_data, imem_ready, redirect_valid, redirect_pc, id_stall
  );

  modport slave (
    input  imem_addr, imem_req, id_valid, id_pc, id_instr,
    output imem_data, imem_ready, redirect_valid, redirect_pc, id_stall
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Owns the fetch PC, prefetches
// sequential 16-bit instructions into a QDEPTH-entry FIFO and presents the
// head {pc, instr} pair to decode. A redirect flushes every queued entry and
// restarts fetch at the redirect target.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - fetch_queue_if.master (imem_*, redirect_*, id_*)
//   perf_fetch_cnt / perf_stall_cnt - only when FETCH_PERF_EN is defined;
//          saturating counts of pushes and of (id_valid && id_stall) cycles.
//
// Optional feature macro: FETCH_PERF_EN.
module fetch_queue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  fetch_queue_if.master       bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         perf_fetch_cnt,
  output logic [15:0]         perf_stall_cnt
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  logic [15:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [15:0]   q_pc    [QDEPTH];
  logic [15:0]   q_instr [QDEPTH];

  logic pop;
  logic req;
  logic push;

  assign bus.id_valid  = (count != '0);
  assign bus.id_pc     = q_pc[head];
  assign bus.id_instr  = q_instr[head];
  assign bus.imem_addr = fetch_pc[11:0];

  assign pop = bus.id_valid && !bus.id_stall && !bus.redirect_valid;
  // A pop frees a slot in the same cycle, so a full queue still requests.
  assign req = !rst && !bus.redirect_valid && ((count < DEPTH) || pop);
  assign bus.imem_req = req;
  assign push = req && bus.imem_ready;

  // QDEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC & 16'hFFFE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Storage contents are left in place; count = 0 hides them.
      fetch_pc <= bus.redirect_pc & 16'hFFFE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        q_pc[tail]    <= fetch_pc;
        q_instr[tail] <= bus.imem_data;
        tail          <= tail + PW'(1);
        fetch_pc      <= fetch_pc + 16'd2;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != 16'hFFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      end
      if (bus.id_valid && bus.id_stall && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with RESET_PC=16'h0100
// and QDEPTH=2. A queue-based model of the fetch front end is compared with
// the DUT on every falling edge; hand-computed literal expectations ("pins")
// are posted by the stimulus and checked by the same compare process.
module tb_fetch_queue;
  localparam logic [15:0] RESET_PC = 16'h0100;
  localparam int          QDEPTH   = 2;

  localparam int S_ADDR  = 0;
  localparam int S_REQ   = 1;
  localparam int S_VALID = 2;
  localparam int S_PC    = 3;
  localparam int S_INSTR = 4;
  localparam int S_PFC   = 5;
  localparam int S_PSC   = 6;

  logic clk;
  logic rst;
  fetch_queue_if bus ();
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  fetch_queue #(
    .RESET_PC(RESET_PC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    string       name;
    int          sel;
    logic [15:0] val;
  } pin_t;

  pin_t        pin_q[$];
  int          pin_rd = 0;
  logic [31:0] exp_q[$];   // model queue of {pc, instr}
  logic [15:0] m_pc;
  logic [15:0] m_pf;
  logic [15:0] m_ps;
  logic        e_valid;
  logic        e_pop;
  logic        e_req;
  logic        e_push;
  int          checks = 0;
  int          errors = 0;
  int          stim   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_val(input int sel);
    logic [15:0] v;
    v = 16'hDEAD;
    case (sel)
      S_ADDR:  v = {4'h0, bus.imem_addr};
      S_REQ:   v = {15'd0, bus.imem_req};
      S_VALID: v = {15'd0, bus.id_valid};
      S_PC:    v = bus.id_pc;
      S_INSTR: v = bus.id_instr;
`ifdef FETCH_PERF_EN
      S_PFC:   v = perf_fetch_cnt;
      S_PSC:   v = perf_stall_cnt;
`endif
      default: v = 16'hDEAD;
    endcase
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", {15'd0, bus.id_valid}, 16'd0);
      chk("rst_req",   {15'd0, bus.imem_req}, 16'd0);
      chk("rst_addr",  {4'h0, bus.imem_addr}, {4'h0, RESET_PC[11:0]});
      chk("rst_pc",    bus.id_pc, 16'h0000);
      chk("rst_instr", bus.id_instr, 16'h0000);
`ifdef FETCH_PERF_EN
      chk("rst_pfc", perf_fetch_cnt, 16'h0000);
      chk("rst_psc", perf_stall_cnt, 16'h0000);
`endif
      exp_q.delete();
      m_pc = RESET_PC & 16'hFFFE;
      m_pf = 16'h0000;
      m_ps = 16'h0000;
    end else begin
      e_valid = (exp_q.size() != 0);
      e_pop   = e_valid && !bus.id_stall && !bus.redirect_valid;
      e_req   = !bus.redirect_valid && ((exp_q.size() < QDEPTH) || e_pop);
      e_push  = e_req && bus.imem_ready;

      chk("valid", {15'd0, bus.id_valid}, {15'd0, e_valid});
      chk("req",   {15'd0, bus.imem_req}, {15'd0, e_req});
      chk("addr",  {4'h0, bus.imem_addr}, {4'h0, m_pc[11:0]});
      if (e_valid) begin
        chk("id_pc",    bus.id_pc,    exp_q[0][31:16]);
        chk("id_instr", bus.id_instr, exp_q[0][15:0]);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, m_pf);
      chk("perf_stall", perf_stall_cnt, m_ps);
`endif

      if (e_push && (m_pf != 16'hFFFF)) m_pf = m_pf + 16'd1;
      if (e_valid && bus.id_stall && (m_ps != 16'hFFFF)) m_ps = m_ps + 16'd1;

      if (bus.redirect_valid) begin
        exp_q.delete();
        m_pc = bus.redirect_pc & 16'hFFFE;
      end else begin
        if (e_pop) exp_q.delete(0);
        if (e_push) begin
          exp_q.push_back({m_pc, bus.imem_data});
          m_pc = m_pc + 16'd2;
        end
      end
    end

    while (pin_rd < pin_q.size()) begin
      chk(pin_q[pin_rd].name, dut_val(pin_q[pin_rd].sel), pin_q[pin_rd].val);
      pin_rd++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic ready, input logic stall,
                       input logic rv, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    rst                = r;
    bus.imem_ready     = ready;
    bus.id_stall       = stall;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_data      = 16'hD000 + 16'(stim);
    stim++;
  endtask

  task automatic pin(input string name, input int sel, input logic [15:0] val);
    pin_t p;
    p.name = name;
    p.sel  = sel;
    p.val  = val;
    pin_q.push_back(p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst                = 1'b1;
    bus.imem_ready     = 1'b0;
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.imem_data      = 16'h0000;
    repeat (3) @(posedge clk);

    // Sequential fetch from RESET_PC, one instruction per cycle.
    drive(0, 1, 0, 0, 16'h0);
    pin("c0_addr", S_ADDR, 16'h0100); pin("c0_req", S_REQ, 16'd1); pin("c0_valid", S_VALID, 16'd0);
    drive(0, 1, 0, 0, 16'h0);
    pin("c1_addr", S_ADDR, 16'h0102); pin("c1_valid", S_VALID, 16'd1);
    pin("c1_pc", S_PC, 16'h0100); pin("c1_instr", S_INSTR, 16'hD000);
    drive(0, 1, 0, 0, 16'h0);
    pin("c2_addr", S_ADDR, 16'h0104); pin("c2_pc", S_PC, 16'h0102);
    drive(0, 1, 0, 0, 16'h0);
    pin("c3_pc", S_PC, 16'h0104);

    // Decode stalls 5 cycles: queue fills to 2, then requests stop.
    drive(0, 1, 1, 0, 16'h0);
    pin("c4_pc", S_PC, 16'h0106); pin("c4_req", S_REQ, 16'd1);
    drive(0, 1, 1, 0, 16'h0);
    pin("c5_req", S_REQ, 16'd0); pin("c5_pc", S_PC, 16'h0106); pin("c5_addr", S_ADDR, 16'h010A);
    drive(0, 1, 1, 0, 16'h0);
    drive(0, 1, 1, 0, 16'h0);
    drive(0, 1, 1, 0, 16'h0);
    pin("c8_pc", S_PC, 16'h0106); pin("c8_req", S_REQ, 16'd0);
    drive(0, 1, 0, 0, 16'h0);
    pin("c9_pc", S_PC, 16'h0106); pin("c9_req", S_REQ, 16'd1); pin("c9_addr", S_ADDR, 16'h010A);
    drive(0, 1, 0, 0, 16'h0);
    pin("c10_pc", S_PC, 16'h0108);
    drive(0, 1, 0, 0, 16'h0);
    pin("c11_pc", S_PC, 16'h010A);

    // Redirect to 0x0200 (bit 0 ignored), then memory not ready 3 cycles.
    drive(0, 1, 0, 1, 16'h0201);
    pin("c12_req", S_REQ, 16'd0);
    drive(0, 0, 0, 0, 16'h0);
    pin("c13_valid", S_VALID, 16'd0); pin("c13_addr", S_ADDR, 16'h0200); pin("c13_req", S_REQ, 16'd1);
    drive(0, 0, 0, 0, 16'h0);
    pin("c14_addr", S_ADDR, 16'h0200);
    drive(0, 0, 0, 0, 16'h0);
    pin("c15_addr", S_ADDR, 16'h0200); pin("c15_valid", S_VALID, 16'd0);
    drive(0, 1, 0, 0, 16'h0);
    pin("c16_addr", S_ADDR, 16'h0200);
    drive(0, 1, 1, 0, 16'h0);
    pin("c17_valid", S_VALID, 16'd1); pin("c17_pc", S_PC, 16'h0200);
    drive(0, 1, 1, 0, 16'h0);
    pin("c18_req", S_REQ, 16'd0);

    // Redirect with a full queue.
    drive(0, 1, 1, 1, 16'h0345);
    pin("c19_valid", S_VALID, 16'd1); pin("c19_req", S_REQ, 16'd0);
    drive(0, 1, 0, 0, 16'h0);
    pin("c20_valid", S_VALID, 16'd0); pin("c20_addr", S_ADDR, 16'h0344);
    drive(0, 1, 0, 0, 16'h0);
    pin("c21_valid", S_VALID, 16'd1); pin("c21_pc", S_PC, 16'h0344);

    // PC wrap at 0xFFFE.
    drive(0, 1, 0, 1, 16'hFFFF);
    pin("c22_req", S_REQ, 16'd0);
    drive(0, 1, 0, 0, 16'h0);
    pin("c23_addr", S_ADDR, 16'h0FFE); pin("c23_valid", S_VALID, 16'd0);
    drive(0, 1, 0, 0, 16'h0);
    pin("c24_addr", S_ADDR, 16'h0000); pin("c24_pc", S_PC, 16'hFFFE);
    drive(0, 1, 0, 0, 16'h0);
    pin("c25_pc", S_PC, 16'h0000);

    // Asynchronous reset mid-operation, then 10 pushes and 4 stall cycles.
    drive(1, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0);
    repeat (6) drive(0, 1, 0, 0, 16'h0);
    repeat (4) drive(0, 1, 1, 0, 16'h0);
    repeat (3) drive(0, 1, 0, 0, 16'h0);
    drive(0, 0, 0, 0, 16'h0);
`ifdef FETCH_PERF_EN
    pin("perf_fetch_10", S_PFC, 16'd10);
    pin("perf_stall_4", S_PSC, 16'd4);
`endif
    pin("end_addr", S_ADDR, 16'h0114);
    drive(0, 0, 0, 0, 16'h0);
    drive(0, 0, 0, 0, 16'h0);
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that drives the instruction bus and feeds the decode stage, which sits directly downstream.
- Owns the architectural fetch PC and prefetches sequential 16-bit instructions into a small FIFO.
- Presents one {pc, instr} pair per cycle to decode with valid/stall handshaking.
- Handles control-flow redirects from the execute stage by flushing all queued wrong-path instructions.

Parameters:
- RESET_PC, 16'h0000, fetch PC value loaded on reset.
- QDEPTH, 2, queue entries; power of two, legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  12  instruction bus address; equals fetch_pc[11:0].
- imem_req  output  1  fetch request for imem_addr in the current cycle.
- imem_data  input  16  instruction word; valid in the same cycle as imem_ready.
- imem_ready  input  1  memory accepts the request and returns data this cycle.
- redirect_valid  input  1  execute stage requests a fetch redirect.
- redirect_pc  input  16  redirect target; bit 0 is ignored.
- id_stall  input  1  decode cannot accept the head entry this cycle.
- id_valid  output  1  head entry is valid.
- id_pc  output  16  PC of the head entry.
- id_instr  output  16  instruction of the head entry.

Behaviour:
- One clock domain, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - fetch_pc = {RESET_PC[15:1], 1'b0}; queue count = 0; all queue storage = 0.
  - id_valid = 0, id_pc = 0, id_instr = 0, imem_req = 0.
  - imem_addr = RESET_PC[11:0].
- Queue head:
  - id_valid = (count != 0). id_pc and id_instr come directly from head storage registers.
  - With count = 0, id_pc and id_instr hold their last values and are don't-care.
- Pop: id_valid && !id_stall && !redirect_valid.
- Request:
  - imem_req = !rst && !redirect_valid && ((count < QDEPTH) || pop).
  - This permits push and pop in the same cycle while the queue is full.
- Accept (push) occurs when imem_req && imem_ready:
  - Write {fetch_pc, imem_data} at the tail; fetch_pc <= fetch_pc + 2.
  - The add is modulo 2^16, so 16'hFFFE wraps to 16'h0000.
  - imem_addr aliases every 4 KiB; this is intentional.
- imem_req high with imem_ready low: no push, fetch_pc holds, imem_addr stable. Request retries every cycle.
- Latency: an instruction accepted in cycle N is visible at id_* in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged; head advances and the new entry lands at the tail.
- Redirect (highest priority):
  - In the redirect cycle: no push, no pop, imem_req = 0.
  - Next edge: count <= 0, head/tail pointers <= 0, fetch_pc <= {redirect_pc[15:1], 1'b0}.
  - Fetch at the new PC begins the following cycle, so the first redirected instruction reaches decode 2 cycles after redirect_valid.
- id_stall held while valid: the head entry and id_* outputs remain stable. Prefetch continues until count = QDEPTH.
- Reset asserted mid-operation immediately forces all reset values; any pending fetch is dropped.
- Stored PCs are always even. No exception is raised for any address.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra output ports are added:
  - perf_fetch_cnt[15:0]: increments on every push.
  - perf_stall_cnt[15:0]: increments every cycle with id_valid && id_stall.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=16'h0100 and imem_ready=1 constantly -> imem_addr 0x100, 0x102, 0x104 on consecutive cycles; id_valid rises 1 cycle after first req; id_pc sequence 0x0100, 0x0102, 0x0104, one per cycle.
- id_stall=1 for 5 cycles with imem_ready=1 -> queue fills to 2, then imem_req=0; id_pc stable at head value; after release, entries drain in order with no loss or duplication.
- imem_ready low 3 cycles at 0x0200 -> imem_addr held at 0x200, no push, id_valid drops after drain; first push occurs on the cycle ready=1.
- redirect_valid=1 with redirect_pc=16'h0345 and queue full -> next cycle id_valid=0, imem_addr=0x344; 0x0344 reaches id_pc 2 cycles after redirect.
- Fetch at 16'hFFFE -> next imem_addr 0x000; id_pc sequence 0xFFFE then 0x0000.
- FETCH_PERF_EN defined, 10 fetches plus 4 stall cycles -> perf_fetch_cnt=10, perf_stall_cnt=4; rst mid-count -> both read 0.
